// File: rtl/eth_mux_sched.sv
// rtl/eth_mux_sched.sv - round-robin frame scheduler driving the eth mux enable/select pair
// Owns one source from header acceptance through the output tlast beat; reports frame count and stalls.
module eth_mux_sched #(
  parameter int S_COUNT       = 4,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [S_COUNT-1:0]         port_mask,
  input  logic [S_COUNT-1:0]         s_eth_hdr_valid,
  input  logic [S_COUNT-1:0]         s_eth_hdr_ready,
  input  logic                       m_eth_payload_axis_tvalid,
  input  logic                       m_eth_payload_axis_tready,
  input  logic                       m_eth_payload_axis_tlast,
  input  logic                       stall_clear,
  output logic                       enable,
  output logic [$clog2(S_COUNT)-1:0] select,
  output logic [S_COUNT-1:0]         grant,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       frame_count,
  output logic                       stall_flag
);
  localparam int SEL_W = $clog2(S_COUNT);
  localparam int ST_W  = $clog2(STALL_TIMEOUT);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STALL_TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(S_COUNT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, FRAME} state_t;

  state_t               state_q, state_d;
  logic                 enable_q, enable_d;
  logic [SEL_W-1:0]     select_q, select_d;
  logic [S_COUNT-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [ST_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                 stall_flag_q, stall_flag_d;

  logic [S_COUNT-1:0]   req;
  logic                 pick_found;
  logic [SEL_W-1:0]     pick_idx;
  logic [SEL_W-1:0]     cand;
  logic [SEL_W-1:0]     next_ptr;
  logic                 beat;
  logic                 stall_set;

  assign req      = s_eth_hdr_valid & port_mask;
  assign beat     = m_eth_payload_axis_tvalid & m_eth_payload_axis_tready;
  assign next_ptr = (select_q == SEL_LAST) ? '0 : select_q + SEL_W'(1);

  // First requesting port at or after the pointer, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      cand = SEL_W'((int'(ptr_q) + i) % S_COUNT);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    select_d      = select_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    frame_count_d = frame_count_q;
    stall_cnt_d   = stall_cnt_q;
    stall_set     = 1'b0;

    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (pick_found) begin
          select_d           = pick_idx;
          grant_d            = '0;
          grant_d[pick_idx]  = 1'b1;
          enable_d           = 1'b1;
          state_d            = GRANT;
        end
      end
      GRANT: begin
        if (s_eth_hdr_valid[select_q] && s_eth_hdr_ready[select_q]) begin
          enable_d    = 1'b0;
          stall_cnt_d = '0;
          state_d     = FRAME;
        end else if (!s_eth_hdr_valid[select_q]) begin
          enable_d = 1'b0;
          grant_d  = '0;
          ptr_d    = next_ptr;
          state_d  = IDLE;
        end
      end
      FRAME: begin
        if (beat) begin
          stall_cnt_d = '0;
          if (m_eth_payload_axis_tlast) begin
            frame_count_d = frame_count_q + CNT_WIDTH'(1);
            ptr_d         = next_ptr;
            grant_d       = '0;
            state_d       = IDLE;
          end
        end else begin
          if (stall_cnt_q != ST_MAX) stall_cnt_d = stall_cnt_q + ST_W'(1);
          stall_set = (stall_cnt_d == ST_MAX);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new stall outranks a simultaneous clear so the event is never lost.
    stall_flag_d = stall_set ? 1'b1 : (stall_clear ? 1'b0 : stall_flag_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      enable_q      <= 1'b0;
      select_q      <= '0;
      grant_q       <= '0;
      ptr_q         <= '0;
      frame_count_q <= '0;
      stall_cnt_q   <= '0;
      stall_flag_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      select_q      <= select_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      frame_count_q <= frame_count_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_flag_q  <= stall_flag_d;
    end
  end

  assign enable      = enable_q;
  assign select      = select_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;
  assign stall_flag  = stall_flag_q;

endmodule

// File: tb/tb_eth_mux_sched.sv
// tb/tb_eth_mux_sched.sv - self-checking bench for eth_mux_sched
// Vector table, directed corner sequences and random traffic against an ownership-level model.
module tb_eth_mux_sched;
  localparam int S  = 4;
  localparam int T  = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [S-1:0]  port_mask, hv, hr;
  logic          tv, tr, tl, stall_clear;
  logic          enable;
  logic [1:0]    select;
  logic [S-1:0]  grant;
  logic          busy;
  logic [CW-1:0] frame_count;
  logic          stall_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eth_mux_sched #(.S_COUNT(S), .STALL_TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .port_mask(port_mask),
    .s_eth_hdr_valid(hv), .s_eth_hdr_ready(hr),
    .m_eth_payload_axis_tvalid(tv), .m_eth_payload_axis_tready(tr),
    .m_eth_payload_axis_tlast(tl), .stall_clear(stall_clear),
    .enable(enable), .select(select), .grant(grant), .busy(busy),
    .frame_count(frame_count), .stall_flag(stall_flag)
  );

  // Model: who owns the mux, whether its header was taken, and the status counters.
  int            m_owner, m_sel, m_ptr, m_idle;
  bit            m_taken, m_stall;
  logic [CW-1:0] m_fc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {23'd0, enable, select, grant, busy, frame_count, stall_flag};
  endfunction

  function automatic logic [63:0] model_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {23'd0, (m_owner >= 0 && !m_taken), 2'(m_sel), g, (m_owner >= 0), m_fc, m_stall};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_idle = 0;
    m_taken = 0; m_stall = 0; m_fc = '0;
  endtask

  task automatic model_step(input logic [S-1:0] v, input logic [S-1:0] r, input logic [S-1:0] mk,
                            input logic b, input logic l, input logic c);
    bit set;
    set = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < S; k++) begin
        int p;
        p = (m_ptr + k) % S;
        if (v[p] && mk[p]) begin
          m_owner = p; m_sel = p; m_taken = 0;
          break;
        end
      end
    end else if (!m_taken) begin
      if (v[m_owner] && r[m_owner]) begin
        m_taken = 1; m_idle = 0;
      end else if (!v[m_owner]) begin
        m_ptr = (m_owner + 1) % S; m_owner = -1;
      end
    end else if (b) begin
      m_idle = 0;
      if (l) begin
        m_fc = m_fc + 1; m_ptr = (m_owner + 1) % S; m_owner = -1;
      end
    end else begin
      if (m_idle < T - 1) m_idle++;
      set = (m_idle == T - 1);
    end
    m_stall = set | (m_stall & ~c);
  endtask

  task automatic step();
    logic [S-1:0] v, r, mk;
    logic b, l, c;
    v = hv; r = hr; mk = port_mask; b = tv & tr; l = tl; c = stall_clear;
    @(posedge clk);
    model_step(v, r, mk, b, l, c);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic clear_inputs();
    hv = '0; hr = '0; port_mask = 4'hF; tv = 0; tr = 0; tl = 0; stall_clear = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_vals", dut_vec(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    clear_inputs();
  endtask

  typedef struct {
    logic [3:0]  v, r, mk;
    logic        tv, tr, tl;
    logic        en;
    logic [1:0]  sel;
    logic [3:0]  g;
    logic        b;
    logic [31:0] fc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    clear_inputs();
    do_reset();

    // single requester, mask gating, withdrawal, held output
    tbl[0]  = '{4'b0100, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 32'd0};
    tbl[1]  = '{4'b0100, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 32'd0};
    tbl[2]  = '{4'b0100, 4'b0100, 4'hF,    1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 32'd0};
    tbl[3]  = '{4'b0000, 4'b0000, 4'hF,    1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 32'd0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'hF,    1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 32'd1};
    tbl[5]  = '{4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 32'd1};
    tbl[6]  = '{4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 32'd1};
    tbl[7]  = '{4'b1010, 4'b0000, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 32'd1};
    tbl[8]  = '{4'b1010, 4'b1000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b1, 32'd1};
    tbl[9]  = '{4'b0000, 4'b0000, 4'hF,    1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 32'd2};
    tbl[10] = '{4'b0010, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 32'd2};
    tbl[11] = '{4'b0100, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 32'd2};
    tbl[12] = '{4'b0100, 4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 32'd2};
    tbl[13] = '{4'b0100, 4'b0100, 4'hF,    1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 32'd2};
    tbl[14] = '{4'b0000, 4'b0000, 4'hF,    1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 32'd2};
    tbl[15] = '{4'b0000, 4'b0000, 4'hF,    1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 32'd3};

    for (int i = 0; i < 16; i++) begin
      hv = tbl[i].v; hr = tbl[i].r; port_mask = tbl[i].mk;
      tv = tbl[i].tv; tr = tbl[i].tr; tl = tbl[i].tl;
      step();
      check($sformatf("vec%0d", i), {24'd0, enable, select, grant, busy, frame_count},
            {24'd0, tbl[i].en, tbl[i].sel, tbl[i].g, tbl[i].b, tbl[i].fc});
    end
    clear_inputs();

    // asynchronous reset in the middle of a frame
    hv = 4'b0001; step();
    hr = 4'b0001; step();
    hv = '0; hr = '0; tv = 1; tr = 1; step();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #3 rst = 1'b1;
    #1 check("async_rst", dut_vec(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    clear_inputs();
    hv = 4'hF; step();
    check("rst_regrant", {57'd0, enable, select, grant}, {57'd0, 1'b1, 2'd0, 4'b0001});

    // fairness: all ports request continuously, 3-beat frames
    do_reset();
    hv = 4'hF;
    for (int f = 0; f < 5; f++) begin
      int w;
      w = 0;
      while (!enable && w < 8) begin
        step();
        w++;
      end
      check("fair_en", {63'd0, enable}, 64'd1);
      check($sformatf("fair_sel%0d", f), {62'd0, select}, 64'(f % 4));
      hr = 4'b0001 << select; step(); hr = '0;
      check("fair_acc", {62'd0, enable, busy}, 64'b01);
      tv = 1; tr = 1; tl = 0; step(); step();
      tl = 1; step();
      tv = 0; tl = 0;
    end
    check("fair_fc", 64'(frame_count), 64'd5);

    // stall: output held off inside a frame
    hv = 4'b0001; step();
    check("stall_grant", {62'd0, select}, 64'd0);
    hr = 4'b0001; step();
    hv = '0; hr = '0; tv = 1; tr = 0; tl = 1;
    check("stall_c1", {63'd0, stall_flag}, 64'd0);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("stall_c%0d", k + 1), {63'd0, stall_flag}, 64'((k + 1) >= 8));
    end
    tr = 1; step();
    tv = 0; tr = 0; tl = 0;
    check("stall_after", {63'd0, stall_flag}, 64'd1);
    check("stall_fc", 64'(frame_count), 64'd6);
    stall_clear = 1; step(); stall_clear = 0;
    check("stall_clr", {63'd0, stall_flag}, 64'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      hv = 4'($urandom);
      hr = 4'($urandom);
      port_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tv = 1'($urandom_range(0, 1));
      tr = ($urandom_range(0, 3) != 0);
      tl = ($urandom_range(0, 2) == 0);
      stall_clear = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
